lupa_pixel_packer: RTL and testbench

Downstream capture stage for the LUPA300 sensor: consumes the sensor's pixel bus qualified by Frame_Valid/Line_Valid, generated once the sensor is configured and integrating. It truncates each 10-bit pixel to 8 bits and packs four pixels per 32-bit word. Each frame is prefixed with a header word, and the result is written into the 32-bit host FIFO. It also checks line and frame geometry and flags FIFO overflow. All logic runs on the 80 MHz pixel clock.

---
 rtl/lupa_pixel_packer.sv | 182 ++++++++++++++++++
 tb/tb_lupa_pixel_packer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lupa_pixel_packer.sv
// rtl/lupa_pixel_packer.sv - LUPA300 capture: 10->8 bit truncation, 4:1 packing, frame header, geometry checks
`timescale 1ns/1ps
module lupa_pixel_packer #(
  parameter int COLS  = 640,
  parameter int ROWS  = 480,
  parameter int PIX_W = 10
) (
  input  logic             iCLOCK_80,
  input  logic             iRESET,
  input  logic             Frame_Valid,
  input  logic             Line_Valid,
  input  logic [PIX_W-1:0] Pix_Data,
  input  logic             enable,
  input  logic             clr_flags,
  input  logic             wr_full,
  output logic             wr_en,
  output logic [31:0]      wr_data,
  output logic [15:0]      frame_cnt,
  output logic             line_err,
  output logic             frame_err,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;

  localparam logic [10:0] COLS_L = 11'(COLS);
  localparam logic [9:0]  ROWS_L = 10'(ROWS);

  logic             d_fval, d_lval, d_fval_q, d_lval_q;
  logic [PIX_W-1:0] d_pix;
  logic             fval_armed;
  logic [1:0]       state, state_n;
  logic [10:0]      col, col_n, col_inc;
  logic [9:0]       row, row_n, row_inc, row_after;
  logic [23:0]      pack, pack_n;
  logic [1:0]       pcnt, pcnt_n;
  logic [15:0]      cnt_n;
  logic             we_n;
  logic [31:0]      wd_n;
  logic             set_le, set_fe, set_ov;
  logic             pix_valid, fval_rise, fval_fall, lval_fall;
  logic [7:0]       pix_byte;
  logic             d_pix_unused_lsbs;

  // A frame already in progress when reset releases must not look like a new rising edge.
  assign fval_rise = d_fval & ~d_fval_q & fval_armed;
  assign fval_fall = ~d_fval & d_fval_q;
  assign lval_fall = ~d_lval & d_lval_q;
  assign pix_valid = d_fval & d_lval;
  assign pix_byte  = d_pix[PIX_W-1 -: 8];
  assign d_pix_unused_lsbs = ^d_pix[PIX_W-9:0];
  assign col_inc   = (col == 11'h7FF) ? col : col + 11'd1;
  assign row_inc   = (row == 10'h3FF) ? row : row + 10'd1;
  assign row_after = lval_fall ? row_inc : row;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n = state;
    col_n   = col;
    row_n   = row;
    pack_n  = pack;
    pcnt_n  = pcnt;
    cnt_n   = frame_cnt;
    we_n    = 1'b0;
    wd_n    = wr_data;
    set_le  = 1'b0;
    set_fe  = 1'b0;
    set_ov  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fval_rise && enable) begin
          cnt_n  = frame_cnt + 16'd1;
          col_n  = '0;
          row_n  = '0;
          pack_n = '0;
          pcnt_n = '0;
          if (wr_full) begin
            set_ov  = 1'b1;
            state_n = S_DROP;
          end else begin
            we_n    = 1'b1;
            wd_n    = {16'hA5A5, frame_cnt + 16'd1};
            state_n = S_ACTIVE;
            if (pix_valid) begin
              pack_n[7:0] = pix_byte;
              pcnt_n      = 2'd1;
              col_n       = 11'd1;
            end
          end
        end
      end
      S_ACTIVE: begin
        if (pix_valid) begin
          col_n = col_inc;
          if (pcnt == 2'd3) begin
            pack_n = '0;
            pcnt_n = '0;
            if (wr_full) begin
              set_ov  = 1'b1;
              state_n = S_DROP;
            end else begin
              we_n = 1'b1;
              wd_n = {pix_byte, pack};
            end
          end else begin
            pack_n[{pcnt, 3'b000} +: 8] = pix_byte;
            pcnt_n = pcnt + 2'd1;
          end
        end
        // Line end can coincide with frame end; flush and line check come first.
        if (lval_fall) begin
          pack_n = '0;
          pcnt_n = '0;
          col_n  = '0;
          row_n  = row_inc;
          set_le = (col != COLS_L);
          if (pcnt != 2'd0) begin
            if (wr_full) begin
              set_ov  = 1'b1;
              state_n = S_DROP;
            end else begin
              we_n = 1'b1;
              wd_n = {8'h00, pack};
            end
          end
        end
        if (fval_fall) begin
          set_fe  = ~set_ov & (row_after != ROWS_L);
          state_n = S_IDLE;
        end
      end
      S_DROP: begin
        if (fval_fall) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK_80) begin
    if (iRESET) begin
      d_fval     <= 1'b0;
      d_lval     <= 1'b0;
      d_fval_q   <= 1'b0;
      d_lval_q   <= 1'b0;
      d_pix      <= '0;
      fval_armed <= 1'b0;
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      pack       <= '0;
      pcnt       <= '0;
      frame_cnt  <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      d_fval     <= Frame_Valid;
      d_lval     <= Line_Valid;
      d_pix      <= Pix_Data;
      d_fval_q   <= d_fval;
      d_lval_q   <= d_lval;
      fval_armed <= fval_armed | ~Frame_Valid;
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      pack       <= pack_n;
      pcnt       <= pcnt_n;
      frame_cnt  <= cnt_n;
      wr_en      <= we_n;
      wr_data    <= wd_n;
      line_err   <= set_le | (line_err & ~clr_flags);
      frame_err  <= set_fe | (frame_err & ~clr_flags);
      overflow   <= set_ov | (overflow & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_lupa_pixel_packer.sv
// tb/tb_lupa_pixel_packer.sv - frame-table bench for lupa_pixel_packer with a word-list reference model
`timescale 1ns/1ps
module tb_lupa_pixel_packer;

  localparam int COLS  = 8;
  localparam int ROWS  = 4;
  localparam int PIX_W = 10;

  logic             iCLOCK_80 = 1'b0;
  logic             iRESET = 1'b1;
  logic             Frame_Valid = 1'b0;
  logic             Line_Valid = 1'b0;
  logic [PIX_W-1:0] Pix_Data = '0;
  logic             enable = 1'b0;
  logic             clr_flags = 1'b0;
  logic             wr_full = 1'b0;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic [15:0]      frame_cnt;
  logic             line_err, frame_err, overflow, busy;

  lupa_pixel_packer #(.COLS(COLS), .ROWS(ROWS), .PIX_W(PIX_W)) dut (
    .iCLOCK_80(iCLOCK_80), .iRESET(iRESET), .Frame_Valid(Frame_Valid), .Line_Valid(Line_Valid),
    .Pix_Data(Pix_Data), .enable(enable), .clr_flags(clr_flags), .wr_full(wr_full),
    .wr_en(wr_en), .wr_data(wr_data), .frame_cnt(frame_cnt), .line_err(line_err),
    .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #6 iCLOCK_80 = ~iCLOCK_80;

  typedef struct {
    int en; int en_toggle; int hdr_full; int nrows; int long_row; int long_len;
    int full_row; int sync_end; int exp_words; int exp_le; int exp_fe; int exp_ov;
  } vec_t;

  vec_t        vt[14];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] got[$];
  int          got_t[$];
  logic [31:0] exp_q[$];
  logic [7:0]  rec_px[$];
  int          rec_len[$];
  logic [15:0] mcnt = '0;
  int          t_hdr, t_w0;

  initial forever begin
    @(posedge iCLOCK_80);
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      got.push_back(wr_data);
      got_t.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge iCLOCK_80);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_line(input int n, input bit first_row, input bit rec);
    logic [PIX_W-1:0] px;
    for (int i = 0; i < n; i++) begin
      px = PIX_W'($urandom_range(0, 1023));
      Line_Valid = 1'b1;
      Pix_Data = px;
      if (rec) rec_px.push_back(px[PIX_W-1 -: 8]);
      if (first_row && i == 3) t_w0 = cyc + 2;
      tick();
    end
    if (rec) rec_len.push_back(n);
  endtask

  task automatic line_gap();
    Line_Valid = 1'b0;
    Pix_Data = PIX_W'($urandom_range(0, 1023));
    repeat (4) tick();
  endtask

  // Expected FIFO contents built from the recorded pixels: header, then each line cut into 4-byte groups.
  task automatic model_frame(input vec_t v);
    int idx;
    int n;
    logic [31:0] w;
    exp_q.delete();
    if (v.en == 0) return;
    mcnt = mcnt + 16'd1;
    if (v.hdr_full != 0) return;
    exp_q.push_back({16'hA5A5, mcnt});
    idx = 0;
    for (int r = 0; r < rec_len.size(); r++) begin
      n = rec_len[r];
      if (r == v.full_row) return;
      for (int k = 0; k < n; k += 4) begin
        w = '0;
        for (int b = 0; b < 4; b++)
          if (k + b < n) w[8*b +: 8] = rec_px[idx + k + b];
        exp_q.push_back(w);
      end
      idx += n;
    end
  endtask

  task automatic run_vector(input vec_t v, input int vi);
    int n;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk($sformatf("v%0d_clr_line_err", vi), {31'b0, line_err}, 32'd0);
    chk($sformatf("v%0d_clr_frame_err", vi), {31'b0, frame_err}, 32'd0);
    chk($sformatf("v%0d_clr_overflow", vi), {31'b0, overflow}, 32'd0);
    got.delete(); got_t.delete(); rec_px.delete(); rec_len.delete();
    enable = (v.en != 0);
    wr_full = (v.hdr_full != 0);
    tick();
    Frame_Valid = 1'b1;
    t_hdr = cyc + 2;
    repeat (3) tick();
    for (int r = 0; r < v.nrows; r++) begin
      if (r == v.full_row) wr_full = 1'b1;
      if (r == 1 && v.en_toggle != 0) enable = (v.en == 0);
      n = (r == v.long_row) ? v.long_len : COLS;
      drive_line(n, r == 0, 1'b1);
      if (r == v.nrows - 1 && v.sync_end != 0) Frame_Valid = 1'b0;
      line_gap();
    end
    Frame_Valid = 1'b0;
    repeat (6) tick();
    wr_full = 1'b0;
    model_frame(v);
    chk($sformatf("v%0d_word_count", vi), got.size(), v.exp_words);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("v%0d_word%0d", vi, i), got[i], exp_q[i]);
    if (got.size() > 0 && exp_q.size() > 0)
      chk($sformatf("v%0d_header_cycle", vi), got_t[0], t_hdr);
    if (got.size() > 1 && exp_q.size() > 1)
      chk($sformatf("v%0d_word0_cycle", vi), got_t[1], t_w0);
    chk($sformatf("v%0d_line_err", vi), {31'b0, line_err}, v.exp_le);
    chk($sformatf("v%0d_frame_err", vi), {31'b0, frame_err}, v.exp_fe);
    chk($sformatf("v%0d_overflow", vi), {31'b0, overflow}, v.exp_ov);
    chk($sformatf("v%0d_frame_cnt", vi), {16'b0, frame_cnt}, {16'b0, mcnt});
    chk($sformatf("v%0d_busy_idle", vi), {31'b0, busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_frame_cnt"}, {16'b0, frame_cnt}, 32'd0);
    chk({tag, "_line_err"}, {31'b0, line_err}, 32'd0);
    chk({tag, "_frame_err"}, {31'b0, frame_err}, 32'd0);
    chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    //         en tog hf rows lrow llen frow sync words le fe ov
    vt[0]  = '{1, 0, 0, 4, -1, 0,    -1, 0, 9,   0, 0, 0};
    vt[1]  = '{1, 0, 0, 4,  1, 10,   -1, 0, 10,  1, 0, 0};
    vt[2]  = '{1, 0, 0, 4, -1, 0,    -1, 0, 9,   0, 0, 0};
    vt[3]  = '{1, 0, 0, 3, -1, 0,    -1, 0, 7,   0, 1, 0};
    vt[4]  = '{1, 0, 0, 4,  2, 5,    -1, 0, 9,   1, 0, 0};
    vt[5]  = '{0, 1, 0, 4, -1, 0,    -1, 0, 0,   0, 0, 0};
    vt[6]  = '{1, 0, 0, 4, -1, 0,     2, 0, 5,   0, 0, 1};
    vt[7]  = '{1, 0, 1, 4, -1, 0,    -1, 0, 0,   0, 0, 1};
    vt[8]  = '{1, 0, 0, 4, -1, 0,    -1, 0, 9,   0, 0, 0};
    vt[9]  = '{1, 0, 0, 5, -1, 0,    -1, 0, 11,  0, 1, 0};
    vt[10] = '{1, 1, 0, 4, -1, 0,    -1, 0, 9,   0, 0, 0};
    vt[11] = '{1, 0, 0, 4,  3, 6,    -1, 1, 9,   1, 0, 0};
    vt[12] = '{1, 0, 0, 4, -1, 0,    -1, 1, 9,   0, 0, 0};
    vt[13] = '{1, 0, 0, 4,  0, 2050, -1, 0, 520, 1, 0, 0};

    repeat (3) tick();
    check_reset_state("reset");
    iRESET = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 14; i++) run_vector(vt[i], i);

    // Reset in the middle of a line while line_err is still set from the last vector.
    enable = 1'b1;
    Frame_Valid = 1'b1;
    repeat (3) tick();
    drive_line(5, 1'b0, 1'b0);
    iRESET = 1'b1;
    tick();
    check_reset_state("midline_reset");
    iRESET = 1'b0;
    got.delete();
    drive_line(3, 1'b0, 1'b0);
    line_gap();
    for (int r = 1; r < ROWS; r++) begin
      drive_line(COLS, 1'b0, 1'b0);
      line_gap();
    end
    Frame_Valid = 1'b0;
    repeat (6) tick();
    chk("post_reset_no_writes", got.size(), 32'd0);
    mcnt = '0;
    run_vector(vt[0], 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
